// File: rtl/buffer_sink_pkg.sv
// Shared defaults and width helpers for the receive-side buffer sink.
// Pointer width is log2(depth); level width adds one bit to represent a full FIFO.
package buffer_sink_pkg;

    localparam int DEF_DATA_WIDTH   = 1;
    localparam int DEF_DEPTH        = 4;
    localparam int DEF_STALL_MARGIN = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/buffer_sink_fifo.sv
// Small circular FIFO: one-cycle write latency, no fall-through; when full, a push is accepted only with a pop.
// A push into a full FIFO without a pop drops the word and sets the sticky overflow flag.
module buffer_sink_fifo
    import buffer_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   head_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  do_push, do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    always_comb begin
        do_pop     = pop & ~empty;
        // A full FIFO still takes a word when the head leaves in the same cycle.
        do_push    = push & (~full | do_pop);
        wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q | (push & ~do_push);
        level_d    = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Storage is not reset, so mask the head while empty to keep outputs at zero out of reset.
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: rtl/buffer_sink.sv
// Realigns a negedge-launched word stream to posedge and buffers it; word visible 2 posedges after launch.
// in_stall is registered and asserts while free entries <= STALL_MARGIN, covering the upstream reaction delay.
module buffer_sink
    import buffer_sink_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int STALL_MARGIN = DEF_STALL_MARGIN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_stall,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
);

    localparam int LVL_W = lvl_w(DEPTH);

    logic                  cap_vld_q, cap_vld_d;
    logic [DATA_WIDTH-1:0] cap_dat_q, cap_dat_d;
    logic                  in_stall_q, in_stall_d;
    logic                  fifo_full, fifo_empty;
    logic                  pop, push_acc;
    logic [LVL_W-1:0]      level_nxt;

    // Half-cycle setup from the falling-edge launch into this rising-edge capture.
    always_comb begin
        cap_vld_d = in_valid;
        cap_dat_d = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld_q  <= 1'b0;
            cap_dat_q  <= '0;
            in_stall_q <= 1'b0;
        end else begin
            cap_vld_q  <= cap_vld_d;
            cap_dat_q  <= cap_dat_d;
            in_stall_q <= in_stall_d;
        end
    end

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    always_comb begin
        push_acc  = cap_vld_q & (~fifo_full | pop);
        level_nxt = level;
        unique case ({push_acc, pop})
            2'b10:   level_nxt = level + LVL_W'(1);
            2'b01:   level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
        endcase
        in_stall_d = (LVL_W'(DEPTH) - level_nxt) <= LVL_W'(STALL_MARGIN);
    end

    buffer_sink_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_vld_q),
        .push_data (cap_dat_q),
        .pop       (pop),
        .head_data (out_data),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign in_stall = in_stall_q;

endmodule

// File: tb/tb_buffer_sink.sv
// Directed and randomized checks of buffer_sink against a queue-based reference model.
module tb_buffer_sink;

    localparam int DW     = 8;
    localparam int DEPTH  = 4;
    localparam int MARGIN = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_stall;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    level;
    logic          overflow;

    buffer_sink #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .STALL_MARGIN (MARGIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_stall  (in_stall),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: stored words, the word sitting in the capture stage, sticky overflow.
    logic [DW-1:0] mq[$];
    logic          cap_v;
    logic [DW-1:0] cap_d;
    logic          ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) check({tag, ".out_data"}, 32'(out_data), 32'(mq[0]));
        check({tag, ".level"}, 32'(level), 32'(mq.size()));
        check({tag, ".in_stall"}, 32'(in_stall), 32'((DEPTH - mq.size()) <= MARGIN));
        check({tag, ".overflow"}, 32'(overflow), 32'(ov));
    endtask

    task automatic model_edge();
        bit pop;
        pop = (mq.size() > 0) && out_ready;
        if (pop) void'(mq.pop_front());
        if (cap_v) begin
            if (mq.size() < DEPTH) mq.push_back(cap_d);
            else ov = 1'b1;
        end
        cap_v = in_valid;
        cap_d = in_data;
    endtask

    // Entered and left at a negedge: inputs are launched, one posedge passes, outputs checked.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, ".rst_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".rst_out_data"},  32'(out_data),  32'd0);
        check({tag, ".rst_level"},     32'(level),     32'd0);
        check({tag, ".rst_in_stall"},  32'(in_stall),  32'd0);
        check({tag, ".rst_overflow"},  32'(overflow),  32'd0);
        mq.delete();
        cap_v     = 1'b0;
        cap_d     = '0;
        ov        = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all({tag, ".post_rst"});
    endtask

    initial begin
        logic [DW-1:0] got[$];
        int            sent;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cap_v     = 1'b0;
        cap_d     = '0;
        ov        = 1'b0;
        @(negedge clk);
        do_reset("init");

        // Reset mid-stream with three words stored and another in flight.
        for (int i = 0; i < 3; i++) cycle("t1_load", 1'b1, DW'(8'h40 + i), 1'b0);
        cycle("t1_load", 1'b0, '0, 1'b0);
        check("t1_level3", 32'(level), 32'd3);
        in_valid = 1'b1;
        in_data  = 8'h77;
        #2;
        do_reset("t1");

        // Single-word latency.
        cycle("t2_launch", 1'b1, 8'hA5, 1'b1);
        check("t2_edgeN_valid", 32'(out_valid), 32'd0);
        cycle("t2_write", 1'b0, '0, 1'b1);
        check("t2_edgeN1_valid", 32'(out_valid), 32'd1);
        check("t2_edgeN1_data", 32'(out_data), 32'hA5);
        cycle("t2_pop", 1'b0, '0, 1'b1);
        check("t2_drop_valid", 32'(out_valid), 32'd0);

        // Fill, then overflow with a fifth word.
        for (int i = 0; i < 4; i++) cycle("t3_fill", 1'b1, DW'(8'h10 + i), 1'b0);
        cycle("t3_settle", 1'b0, '0, 1'b0);
        check("t3_full_level", 32'(level), 32'd4);
        check("t3_no_overflow", 32'(overflow), 32'd0);
        cycle("t4_extra", 1'b1, 8'h55, 1'b0);
        cycle("t4_drop", 1'b0, '0, 1'b0);
        check("t4_overflow_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t4_pop_order", 32'(out_data), 32'(8'h10 + i));
            cycle("t4_pop", 1'b0, '0, 1'b1);
        end
        check("t4_overflow_sticky", 32'(overflow), 32'd1);

        // Full with simultaneous push and pop.
        do_reset("t5");
        for (int i = 0; i < 4; i++) cycle("t5_fill", 1'b1, DW'(8'h20 + i), 1'b0);
        cycle("t5_extra", 1'b1, 8'h24, 1'b0);
        cycle("t5_swap", 1'b0, '0, 1'b1);
        check("t5_level_kept", 32'(level), 32'd4);
        check("t5_no_overflow", 32'(overflow), 32'd0);
        for (int i = 1; i < 5; i++) begin
            check("t5_order", 32'(out_data), 32'(8'h20 + i));
            cycle("t5_drain", 1'b0, '0, 1'b1);
        end

        // Stream 0..19 with ready toggling, upstream honouring in_stall.
        sent = 0;
        for (int c = 0; c < 200 && got.size() < 20; c++) begin
            logic r;
            logic v;
            r = (c % 2) == 0;
            v = (sent < 20) && !in_stall;
            if (out_valid && r) got.push_back(out_data);
            cycle("t6_stream", v, DW'(sent), r);
            if (v) sent++;
            check("t6_level_bound", 32'(level <= 3'd4), 32'd1);
        end
        check("t6_count", 32'(got.size()), 32'd20);
        for (int i = 0; i < got.size(); i++) check("t6_seq", 32'(got[i]), 32'(i));

        // Unconstrained random traffic, including overflow.
        for (int c = 0; c < 300; c++) begin
            cycle("rand", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        for (int c = 0; c < 8; c++) cycle("rand_drain", 1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
